// File: rtl/kb_pkg.sv
// Shared constants for the PS/2 Set-2 keyboard decoder: scancodes, FSM encoding, ASCII controls.
package kb_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

endpackage

// File: rtl/kb_ascii_rom.sv
// Combinational Set-2 scancode to ASCII translation; 0x00 marks a non-printable code.
module kb_ascii_rom
  import kb_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic       letter;
  logic [7:0] lo;
  logic [7:0] hi;

  always_comb begin
    letter = 1'b0;
    lo     = 8'h00;
    hi     = 8'h00;
    case (code)
      8'h1C: begin letter = 1'b1; lo = "a"; end
      8'h32: begin letter = 1'b1; lo = "b"; end
      8'h21: begin letter = 1'b1; lo = "c"; end
      8'h23: begin letter = 1'b1; lo = "d"; end
      8'h24: begin letter = 1'b1; lo = "e"; end
      8'h2B: begin letter = 1'b1; lo = "f"; end
      8'h34: begin letter = 1'b1; lo = "g"; end
      8'h33: begin letter = 1'b1; lo = "h"; end
      8'h43: begin letter = 1'b1; lo = "i"; end
      8'h3B: begin letter = 1'b1; lo = "j"; end
      8'h42: begin letter = 1'b1; lo = "k"; end
      8'h4B: begin letter = 1'b1; lo = "l"; end
      8'h3A: begin letter = 1'b1; lo = "m"; end
      8'h31: begin letter = 1'b1; lo = "n"; end
      8'h44: begin letter = 1'b1; lo = "o"; end
      8'h4D: begin letter = 1'b1; lo = "p"; end
      8'h15: begin letter = 1'b1; lo = "q"; end
      8'h2D: begin letter = 1'b1; lo = "r"; end
      8'h1B: begin letter = 1'b1; lo = "s"; end
      8'h2C: begin letter = 1'b1; lo = "t"; end
      8'h3C: begin letter = 1'b1; lo = "u"; end
      8'h2A: begin letter = 1'b1; lo = "v"; end
      8'h1D: begin letter = 1'b1; lo = "w"; end
      8'h22: begin letter = 1'b1; lo = "x"; end
      8'h35: begin letter = 1'b1; lo = "y"; end
      8'h1A: begin letter = 1'b1; lo = "z"; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h45: begin lo = "0"; hi = ")"; end
      8'h0E: begin lo = 8'h60; hi = "~"; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h5D: begin lo = "\\"; hi = "|"; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = "'"; hi = "\""; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      8'h29: begin lo = " "; hi = " "; end
      8'h5A: begin lo = ASCII_CR;  hi = ASCII_CR;  end
      8'h66: begin lo = ASCII_BS;  hi = ASCII_BS;  end
      8'h0D: begin lo = ASCII_TAB; hi = ASCII_TAB; end
      8'h76: begin lo = ASCII_ESC; hi = ASCII_ESC; end
      default: ;
    endcase
    // Letters fold case with Shift XOR Caps; everything else only follows Shift.
    if (letter)
      ascii = (shift ^ caps) ? (lo - 8'h20) : lo;
    else
      ascii = shift ? hi : lo;
  end

endmodule

// File: rtl/kb_decode.sv
// PS/2 Set-2 decoder: make/break/extended FSM, Shift/Caps tracking, ASCII FIFO toward the CPU.
// Optional: define KB_BREAK_PUSH_EN to also queue breaks of printable keys with bit7 set.
module kb_decode
    import kb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            code_i,
    input  logic                  ready_i,
    input  logic                  rd_i,
    input  logic                  clr_ovf_i,
    output logic [7:0]            data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    output logic                  shift_o,
    output logic                  caps_o
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]            state;
    logic                  lshift_held;
    logic                  rshift_held;
    logic                  caps_held;
    logic                  caps;
    logic [7:0]            ascii;
    logic                  is_ignored;
    logic                  push_req;
    logic [7:0]            push_data;
    logic                  push_ok;
    logic                  pop;
    logic                  ovf_set;
    logic [7:0]            mem [DEPTH_CNT];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    assign shift_o = lshift_held | rshift_held;
    assign caps_o  = caps;

    kb_ascii_rom u_rom (
        .code  (code_i),
        .shift (shift_o),
        .caps  (caps),
        .ascii (ascii)
    );

    always_comb begin
        is_ignored = (code_i == 8'hAA) || (code_i == 8'hFA) || (code_i == 8'hEE) ||
                     (code_i == 8'hFE) || (code_i == 8'h00) || (code_i == 8'hFF);
        push_req   = 1'b0;
        push_data  = ascii;
        if (ready_i) begin
            case (state)
                ST_IDLE: begin
                    if (code_i != SC_EXT && code_i != SC_BREAK && !is_ignored && ascii != 8'h00)
                        push_req = 1'b1;
                end
`ifdef KB_BREAK_PUSH_EN
                ST_BRK: begin
                    if (ascii != 8'h00) begin
                        push_req  = 1'b1;
                        push_data = {1'b1, ascii[6:0]};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            caps_held   <= 1'b0;
            caps        <= 1'b0;
        end else if (ready_i) begin
            case (state)
                ST_IDLE: begin
                    if (code_i == SC_EXT) begin
                        state <= ST_EXT;
                    end else if (code_i == SC_BREAK) begin
                        state <= ST_BRK;
                    end else if (!is_ignored) begin
                        if (code_i == SC_LSHIFT) lshift_held <= 1'b1;
                        if (code_i == SC_RSHIFT) rshift_held <= 1'b1;
                        // caps_held suppresses typematic repeats from re-toggling.
                        if (code_i == SC_CAPS) begin
                            if (!caps_held) caps <= ~caps;
                            caps_held <= 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    state <= ST_IDLE;
                    if (code_i == SC_LSHIFT) lshift_held <= 1'b0;
                    if (code_i == SC_RSHIFT) rshift_held <= 1'b0;
                    if (code_i == SC_CAPS)   caps_held   <= 1'b0;
                end
                ST_EXT:  state <= (code_i == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a push when the same cycle pops.
    assign pop     = rd_i && (count != '0);
    assign push_ok = push_req && ((count != DEPTH_CNT) || pop);
    assign ovf_set = push_req && !push_ok;

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (ovf_set)        overflow_o <= 1'b1;
            else if (clr_ovf_i) overflow_o <= 1'b0;
        end
    end

    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = (count == DEPTH_CNT);
    assign data_o  = empty_o ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/kb_decode.md
Name: kb_decode

Overview:
- Consumes the scancode stream from the PS/2 scan stage (8-bit code plus a one-cycle ready pulse) and interprets PS/2 Set-2 make, break (F0) and extended (E0) sequences.
- Tracks Shift and Caps Lock state and translates make codes of printable keys to ASCII.
- Queues the ASCII characters in a FIFO that the CPU-side keyboard peripheral pops one at a time.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (16).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset (see interface rule below).
- code_i  in  8  scancode from the scan stage; valid only while ready_i=1.
- ready_i  in  1  one-cycle strobe: code_i holds a new byte.
- rd_i  in  1  pop request from the bus side.
- clr_ovf_i  in  1  clears overflow_o.
- data_o  out  8  FIFO head (first-word-fall-through); 0x00 when empty.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- count_o  out  DEPTH_LOG2+1  entries held.
- overflow_o  out  1  sticky: a character was dropped.
- shift_o  out  1  either Shift key held.
- caps_o  out  1  Caps Lock latched.

Interface rule: one clock; reset is synchronous and active-high. The clock port is clk_i and the reset port is rst_i.

Behaviour:
- Reset values (on the first clk_i edge with rst_i=1): FSM=IDLE; FIFO pointers=0; empty_o=1, full_o=0, count_o=0, data_o=0x00; overflow_o=0; shift_o=0; caps_o=0; caps_held=0. Reset overrides every other input in that cycle.
- Reset mid-sequence (e.g. after F0) discards the partial sequence.
- FSM states: IDLE, BRK, EXT, EXT_BRK. It advances only on cycles with ready_i=1.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make of that code -> IDLE.
  - BRK: the byte is a break of that code -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make, ignored -> IDLE.
  - EXT_BRK: the byte is an extended break, ignored -> IDLE.
  - Bytes AA, FA, EE, FE, 00 and FF in IDLE are ignored, with no state change.
- Modifiers:
  - Make of 0x12 or 0x59 sets the respective held bit; break clears it. shift_o is the OR of the two held bits.
  - Make of 0x58 toggles caps_o only if caps_held=0, then sets caps_held. Break of 0x58 clears caps_held, so typematic repeats do not toggle.
- Translation is done by the kb_ascii_rom sub-module:
  - Letters: upper case when shift_o XOR caps_o.
  - Digits and punctuation: use the shifted glyph when shift_o=1 (caps_o has no effect).
  - Fixed codes: 0x29 -> 0x20; 0x5A -> 0x0D; 0x66 -> 0x08; 0x0D -> 0x09; 0x76 -> 0x1B.
  - Unmapped codes -> 0x00, which is never pushed.
- Push timing: a make of a printable key with ready_i at edge N writes the FIFO at edge N. data_o and empty_o reflect the new entry after that edge (1-cycle latency).
- Pop: rd_i=1 with empty_o=0 advances the head at the edge. rd_i while empty is ignored.
- Push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - When full, this pair still succeeds with no overflow.
- Push when full with no pop: the character is dropped and overflow_o is set.
- overflow_o clears on clr_ovf_i. If set and clear coincide, set wins.
- Pointers wrap modulo 2**DEPTH_LOG2. count_o ranges 0..2**DEPTH_LOG2.

Optional Feature:
- Macro KB_BREAK_PUSH_EN.
- Defined: a non-extended break of a printable key pushes {1'b1, ascii[6:0]}, using the same Shift/Caps rules. Make entries keep bit7=0.
- Undefined: breaks never push; every entry has bit7=0.

Decomposition:
- Shared package kb_pkg holds:
  - scancode constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58;
  - the FSM state encoding;
  - ASCII constants for CR, BS, TAB and ESC.
- One sub-module, kb_ascii_rom: combinational, (code[7:0], shift, caps) -> ascii[7:0], where 0x00 means non-printable.
- The FIFO is inline.

Test Plan:
- Reset, then codes 1C, F0, 1C -> exactly one entry 0x61 ('a'); count_o=1; rd_i pop -> empty_o=1, data_o=0x00.
- Codes 12, 16, F0, 16, F0, 12 -> one entry 0x21 ('!'); shift_o goes 1 then returns to 0.
- Codes 58, 58, F0, 58, 1C (typematic Caps) -> caps_o=1; entry 0x41. Then 12, 1C -> entry 0x61 (Shift XOR Caps).
- Codes E0, 75, E0, F0, 75, then 5A -> only 0x0D is queued; the FSM ends in IDLE.
- 17 makes of 0x29 without popping -> full_o=1, count_o=16, overflow_o=1. A push plus rd_i in the same cycle while full -> count stays 16 and there is no new overflow. clr_ovf_i -> overflow_o=0.
- rst_i asserted after F0 has been received, then 1C -> entry 0x61 (no stale break state).
